piso_serializer_hs: RTL and testbench

//   Parametrised parallel-in serial-out serializer with handshake on both sides.
//   - Captures a WIDTH-bit word via valid/ready and shifts it out one bit per accepted beat.
//   - Supports MSB-first or LSB-first order, downstream stall (ser_ready) and a per-word last flag.
//   - Supports gap-free back-to-back words.
//   - Sits between a parallel word producer and any bit-serial link (SPI-like TX, UART datapath, test stream).

---
 rtl/piso_serializer_hs.sv | 82 ++++++++
 tb/tb_piso_serializer_hs.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer_hs.sv
// Parallel-in serial-out serializer with valid/ready handshakes on both sides.
// Ports: clk, rst (async high); load_valid/load_ready/parallel_in accept a word;
//        ser_out/ser_valid/ser_ready/ser_last stream it out; busy mirrors ser_valid.
module piso_serializer_hs #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic beat;
    logic accept;

    // Outputs decode straight from the registers, so an async reset
    // takes them to idle values without waiting for a clock edge.
    always_comb begin
        ser_valid  = (state_q == SHIFT);
        ser_last   = ser_valid && (cnt_q == CNT_LAST);
        busy       = ser_valid;
        ser_out    = IDLE_LEVEL;
        if (ser_valid) begin
            ser_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end
        // Ready on the last beat lets the next word follow with no gap.
        load_ready = !ser_valid || (ser_last && ser_ready);
        beat       = ser_valid && ser_ready;
        accept     = load_valid && load_ready;
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SHIFT;
            shreg_d = parallel_in;
            cnt_d   = '0;
        end else if (beat && ser_last) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (beat) begin
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer_hs.sv
// Self-checking bench for piso_serializer_hs: directed scenarios plus random
// traffic checked against a bit-queue model of the serial stream.
module tb_piso_serializer_hs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] parallel_in = '0;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_ready = 1'b0;
    logic       ser_last;
    logic       busy;

    logic       lv8 = 1'b0;
    logic       lr8;
    logic [7:0] pin8 = '0;
    logic       so8;
    logic       sv8;
    logic       sr8 = 1'b0;
    logic       sl8;
    logic       busy8;

    int errors = 0;
    int checks = 0;
    int beats;
    logic [31:0] cap;
    logic [1:0]  exp_q[$];

    always #5 clk = ~clk;

    piso_serializer_hs #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready),
        .parallel_in(parallel_in),
        .ser_out(ser_out), .ser_valid(ser_valid),
        .ser_ready(ser_ready), .ser_last(ser_last), .busy(busy)
    );

    piso_serializer_hs #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut8 (
        .clk(clk), .rst(rst),
        .load_valid(lv8), .load_ready(lr8),
        .parallel_in(pin8),
        .ser_out(so8), .ser_valid(sv8),
        .ser_ready(sr8), .ser_last(sl8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, check at the falling edge against the model,
    // then advance the model by what the next rising edge will do.
    task automatic step(input logic lv, input logic [3:0] pin,
                        input logic sr);
        logic [1:0] e;
        logic       acc;
        int         n;
        load_valid  = lv;
        parallel_in = pin;
        ser_ready   = sr;
        @(negedge clk);
        n = exp_q.size();
        chk("ser_valid", ser_valid, n != 0);
        chk("busy", busy, n != 0);
        chk("load_ready", load_ready, (n == 0) || (n == 1 && sr));
        if (n == 0) begin
            chk("idle_out", ser_out, 0);
            chk("idle_last", ser_last, 0);
        end else begin
            e = exp_q[0];
            chk("ser_out", ser_out, e[1]);
            chk("ser_last", ser_last, e[0]);
        end
        acc = lv && ((n == 0) || (n == 1 && sr));
        if (n != 0 && sr) begin
            e = exp_q.pop_front();
            beats++;
            cap = {cap[30:0], ser_out};
        end
        if (acc) begin
            for (int i = 3; i >= 0; i--) exp_q.push_back({pin[i], i == 0});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid", ser_valid, 0);
        chk("rst_last", ser_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out", ser_out, 0);
        chk("rst_out8", so8, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", load_ready, 1);

        // 1. single word
        beats = 0; cap = 0;
        step(1, 4'b1011, 1);
        for (int i = 0; i < 4; i++) step(0, 4'b0000, 1);
        step(0, 4'b0000, 1);
        chk("t1_word", cap[3:0], 4'b1011);
        chk("t1_beats", beats, 4);

        // 2. back-to-back
        beats = 0; cap = 0;
        step(1, 4'b1011, 1);
        for (int i = 0; i < 4; i++) step(1, 4'b0110, 1);
        for (int i = 0; i < 4; i++) step(0, 4'b0000, 1);
        step(0, 4'b0000, 1);
        chk("t2_word", cap[7:0], 8'b1011_0110);
        chk("t2_beats", beats, 8);

        // 3. stall after 2nd bit
        beats = 0; cap = 0;
        step(1, 4'b1001, 1);
        step(0, 4'b0000, 1);
        step(0, 4'b0000, 1);
        for (int i = 0; i < 3; i++) step(0, 4'b0000, 0);
        step(0, 4'b0000, 1);
        step(0, 4'b0000, 1);
        step(0, 4'b0000, 1);
        chk("t3_word", cap[3:0], 4'b1001);
        chk("t3_beats", beats, 4);

        // 4. busy rejection
        beats = 0; cap = 0;
        step(1, 4'b0000, 1);
        for (int i = 0; i < 4; i++) step(1, 4'b1111, 1);
        for (int i = 0; i < 4; i++) step(0, 4'b0000, 1);
        step(0, 4'b0000, 1);
        chk("t4_word", cap[7:0], 8'b0000_1111);
        chk("t4_beats", beats, 8);

        // 5. reset mid-word (now #1 after the edge where bit 2 appears)
        step(1, 4'b1101, 1);
        step(0, 4'b0000, 1);
        load_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t5_valid", ser_valid, 0);
        chk("t5_out", ser_out, 0);
        chk("t5_last", ser_last, 0);
        chk("t5_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        beats = 0; cap = 0;
        step(1, 4'b0011, 1);
        for (int i = 0; i < 4; i++) step(0, 4'b0000, 1);
        step(0, 4'b0000, 1);
        chk("t5_word", cap[3:0], 4'b0011);
        chk("t5_beats", beats, 4);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom),
                 1'(($urandom % 4) != 0));
        end
        while (exp_q.size() != 0) step(0, 4'b0000, 1);
        step(0, 4'b0000, 1);

        // 6. WIDTH=8, LSB first, idle high
        chk("t6_idle", so8, 1);
        lv8 = 1'b1; pin8 = 8'hA5; sr8 = 1'b1;
        @(negedge clk);
        chk("t6_ready", lr8, 1);
        @(posedge clk);
        #1;
        lv8 = 1'b0; pin8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6_valid", sv8, 1);
            chk("t6_bit", so8, (8'hA5 >> i) & 1);
            chk("t6_last", sl8, i == 7);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("t6_end_valid", sv8, 0);
        chk("t6_end_out", so8, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
